// File: rtl/first_nios2_system_sysid_pkg.sv
// Shared constants for the system ID checker: word addresses, FSM encoding
// and the word comparison helper.
package first_nios2_system_sysid_pkg;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  typedef logic [2:0] state_t;

  localparam state_t ST_WAIT      = 3'd0;
  localparam state_t ST_RD_ID     = 3'd1;
  localparam state_t ST_RD_TS     = 3'd2;
  localparam state_t ST_RETRY_GAP = 3'd3;
  localparam state_t ST_CHECK     = 3'd4;
  localparam state_t ST_DONE      = 3'd5;

  function automatic logic word_matches(input logic [31:0] a, input logic [31:0] b);
    return a == b;
  endfunction

endpackage

// File: rtl/first_nios2_system_sysid_checker_timer.sv
// Shared delay/timeout counter plus per-word retry counter; the FSM drives the
// clear/increment controls and reacts to the expiry strobes.
module first_nios2_system_sysid_checker_timer
  import first_nios2_system_sysid_pkg::*;
#(
  parameter int START_DELAY    = 16,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int MAX_RETRIES    = 3
) (
  input  logic clock,
  input  logic reset_n,
  input  logic i_cnt_clr,
  input  logic i_cnt_inc,
  input  logic i_retry_clr,
  input  logic i_retry_inc,
  output logic o_delay_done,
  output logic o_timeout,
  output logic o_retries_spent
);

  logic [15:0] r_cnt;
  logic [4:0]  r_retry;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_cnt_clr) begin
      r_cnt <= '0;
    end else if (i_cnt_inc) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  // Five bits so the count can reach MAX_RETRIES+1 even when MAX_RETRIES=15.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_retry <= '0;
    end else if (i_retry_clr) begin
      r_retry <= '0;
    end else if (i_retry_inc) begin
      r_retry <= r_retry + 5'd1;
    end
  end

  assign o_delay_done    = (r_cnt == 16'(START_DELAY - 1));
  assign o_timeout       = (r_cnt == 16'(TIMEOUT_CYCLES - 1));
  assign o_retries_spent = (r_retry > 5'(MAX_RETRIES));

endmodule

// File: rtl/first_nios2_system_sysid_checker.sv
// Avalon-MM master that reads the system ID and timestamp words after reset
// (or on start) and flags any mismatch against the build-time values.
module first_nios2_system_sysid_checker
  import first_nios2_system_sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1353072478,
  parameter int          START_DELAY        = 16,
  parameter int          TIMEOUT_CYCLES     = 255,
  parameter int          MAX_RETRIES        = 3
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic [31:0] id_value,
  output logic [31:0] timestamp_value,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        id_mismatch,
  output logic        ts_mismatch,
  output logic        timeout_err
);

  state_t      r_state;
  state_t      w_state_next;
  logic        r_word;
  logic [31:0] r_id_value;
  logic [31:0] r_ts_value;
  logic        r_busy;
  logic        r_done;
  logic        r_pass;
  logic        r_id_mismatch;
  logic        r_ts_mismatch;
  logic        r_timeout_err;

  logic w_cnt_clr;
  logic w_cnt_inc;
  logic w_retry_clr;
  logic w_retry_inc;
  logic w_delay_done;
  logic w_timeout;
  logic w_retries_spent;

  first_nios2_system_sysid_checker_timer #(
    .START_DELAY    (START_DELAY),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .MAX_RETRIES    (MAX_RETRIES)
  ) u_timer (
    .clock           (clock),
    .reset_n         (reset_n),
    .i_cnt_clr       (w_cnt_clr),
    .i_cnt_inc       (w_cnt_inc),
    .i_retry_clr     (w_retry_clr),
    .i_retry_inc     (w_retry_inc),
    .o_delay_done    (w_delay_done),
    .o_timeout       (w_timeout),
    .o_retries_spent (w_retries_spent)
  );

  // Decoded straight from the state register so reset drops the request at once.
  assign avm_read    = (r_state == ST_RD_ID) || (r_state == ST_RD_TS);
  assign avm_address = (r_state == ST_RD_TS) ? SYSID_ADDR_TS : SYSID_ADDR_ID;

  always_comb begin
    w_state_next = r_state;
    w_cnt_clr    = 1'b0;
    w_cnt_inc    = 1'b0;
    w_retry_clr  = 1'b0;
    w_retry_inc  = 1'b0;
    case (r_state)
      ST_WAIT: begin
        if (w_delay_done) begin
          w_state_next = ST_RD_ID;
          w_cnt_clr    = 1'b1;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      ST_RD_ID, ST_RD_TS: begin
        if (!avm_waitrequest) begin
          w_state_next = (r_state == ST_RD_ID) ? ST_RD_TS : ST_CHECK;
          w_cnt_clr    = 1'b1;
          w_retry_clr  = 1'b1;
        end else if (w_timeout) begin
          w_state_next = ST_RETRY_GAP;
          w_cnt_clr    = 1'b1;
          w_retry_inc  = 1'b1;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      ST_RETRY_GAP: begin
        if (w_retries_spent) begin
          w_state_next = ST_DONE;
          w_retry_clr  = 1'b1;
        end else begin
          w_state_next = r_word ? ST_RD_TS : ST_RD_ID;
        end
      end
      ST_CHECK: w_state_next = ST_DONE;
      ST_DONE: begin
        w_cnt_clr   = 1'b1;
        w_retry_clr = 1'b1;
        if (start) begin
          w_state_next = ST_RD_ID;
        end
      end
      default: w_state_next = ST_WAIT;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_WAIT;
      r_word        <= SYSID_ADDR_ID;
      r_id_value    <= '0;
      r_ts_value    <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_pass        <= 1'b0;
      r_id_mismatch <= 1'b0;
      r_ts_mismatch <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_busy  <= (w_state_next != ST_DONE);
      r_done  <= (w_state_next == ST_DONE);
      case (r_state)
        ST_RD_ID: begin
          r_word <= SYSID_ADDR_ID;
          if (!avm_waitrequest) r_id_value <= avm_readdata;
        end
        ST_RD_TS: begin
          r_word <= SYSID_ADDR_TS;
          if (!avm_waitrequest) r_ts_value <= avm_readdata;
        end
        ST_RETRY_GAP: begin
          if (w_retries_spent) r_timeout_err <= 1'b1;
        end
        ST_CHECK: begin
          r_id_mismatch <= !word_matches(r_id_value, EXPECTED_ID);
          r_ts_mismatch <= !word_matches(r_ts_value, EXPECTED_TIMESTAMP);
          r_pass        <= word_matches(r_id_value, EXPECTED_ID) &&
                           word_matches(r_ts_value, EXPECTED_TIMESTAMP);
        end
        ST_DONE: begin
          if (start) begin
            r_id_value    <= '0;
            r_ts_value    <= '0;
            r_pass        <= 1'b0;
            r_id_mismatch <= 1'b0;
            r_ts_mismatch <= 1'b0;
            r_timeout_err <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign id_value        = r_id_value;
  assign timestamp_value = r_ts_value;
  assign busy            = r_busy;
  assign done            = r_done;
  assign pass            = r_pass;
  assign id_mismatch     = r_id_mismatch;
  assign ts_mismatch     = r_ts_mismatch;
  assign timeout_err     = r_timeout_err;

endmodule
